// File: rtl/img_row_pair_sel.sv
// Resolves the resident 8-row slot pair (floor(h), floor(h)+1) for the bilinear interpolator.
// Optional checker: define IMG_ROW_CHK_EN to enable the sticky o_err consistency checks.
module img_row_pair_sel #(
    parameter int IMG_H_MAX = 479
) (
    input  logic        clk,
    input  logic        frst_n,
    input  logic [8:0]  i_req_h,
    input  logic        i_req_vld,
    input  logic [14:0] i_fix_h,
    input  logic        i_fix_h_vld,
    input  logic        i_fix_h_empty,
    output logic        o_fix_h_re,
    input  logic [2:0]  i_8row_id,
    input  logic [8:0]  i_8row_h,
    input  logic        i_8row_empty,
    output logic        o_8row_re,
    output logic [2:0]  o_pair_id0,
    output logic [2:0]  o_pair_id1,
    output logic [8:0]  o_pair_h0,
    output logic [4:0]  o_pair_frac,
    output logic        o_pair_oob,
    output logic        o_pair_vld,
    input  logic        i_pair_ready,
    input  logic        i_line_done,
    output logic        o_err,
    output logic [2:0]  o_dbg_state
);

    localparam logic [8:0] H_MAX = 9'(IMG_H_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_RELEASE, S_WAIT_ROWS, S_PRESENT, S_BUSY
    } state_t;

    state_t     state;
    logic [8:0] mir_h [8];
    logic [7:0] mir_vld;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] cnt;
    logic [8:0] h1_q;

    logic [2:0] rd_nxt;
    logic [8:0] fix_h0;
    logic [8:0] fix_h1;
    logic       req_wr;
    logic       rel_go;
    logic       rows_ok;

    assign rd_nxt  = rd_ptr + 3'd1;
    assign fix_h0  = i_fix_h[13:5];
    assign fix_h1  = (fix_h0 >= H_MAX) ? fix_h0 : fix_h0 + 9'd1;
    assign req_wr  = i_req_vld && (cnt != 4'd8);
    assign rel_go  = (state == S_RELEASE) && (cnt != 4'd0) && mir_vld[rd_ptr]
                     && (mir_h[rd_ptr] < o_pair_h0);
    assign rows_ok = (cnt >= 4'd1) && mir_vld[rd_ptr] && (mir_h[rd_ptr] == o_pair_h0)
                     && ((h1_q == o_pair_h0)
                         || ((cnt >= 4'd2) && mir_vld[rd_nxt] && (mir_h[rd_nxt] == h1_q)));
    assign o_dbg_state = state;

    // Row numbers need no reset: every read is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (req_wr) begin
            mir_h[wr_ptr] <= i_req_h;
        end
    end

    // Pair handshake: o_pair_vld and all o_pair_* stay stable until a cycle with
    // i_pair_ready high; the pair is transferred on that clock edge and o_pair_vld
    // drops the cycle after. i_line_done then frees the slot for the next pair.
    always_ff @(posedge clk or negedge frst_n) begin
        if (!frst_n) begin
            state       <= S_IDLE;
            mir_vld     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            h1_q        <= '0;
            o_fix_h_re  <= 1'b0;
            o_8row_re   <= 1'b0;
            o_pair_id0  <= '0;
            o_pair_id1  <= '0;
            o_pair_h0   <= '0;
            o_pair_frac <= '0;
            o_pair_oob  <= 1'b0;
            o_pair_vld  <= 1'b0;
        end else begin
            o_fix_h_re <= 1'b0;
            o_8row_re  <= 1'b0;
            if (req_wr) begin
                mir_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 3'd1;
            end
            // An empty 8-row FIFO suppresses the pop but the mirror still advances.
            if (rel_go) begin
                mir_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_nxt;
                o_8row_re       <= ~i_8row_empty;
            end
            cnt <= cnt + {3'b000, req_wr} - {3'b000, rel_go};

            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (!i_fix_h_empty) begin
                        o_fix_h_re  <= 1'b1;
                        o_pair_h0   <= fix_h0;
                        h1_q        <= fix_h1;
                        o_pair_frac <= i_fix_h[4:0];
                        o_pair_oob  <= ~i_fix_h_vld;
                        state       <= i_fix_h_vld ? S_RELEASE : S_PRESENT;
                    end
                end
                S_RELEASE: begin
                    if (!rel_go) begin
                        state <= S_WAIT_ROWS;
                    end
                end
                S_WAIT_ROWS: begin
                    if (rows_ok) begin
                        o_pair_id0 <= rd_ptr;
                        o_pair_id1 <= (h1_q == o_pair_h0) ? rd_ptr : rd_nxt;
                        o_pair_vld <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    // Blank lines arrive here with valid still low; raise it first.
                    if (!o_pair_vld) begin
                        o_pair_vld <= 1'b1;
                    end else if (i_pair_ready) begin
                        o_pair_vld <= 1'b0;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_line_done) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IMG_ROW_CHK_EN
    logic [2:0] chk_id;
    logic [8:0] chk_h;

    // The pop lands one cycle after the release decision, so the expected head is staged.
    always_ff @(posedge clk or negedge frst_n) begin
        if (!frst_n) begin
            chk_id <= '0;
            chk_h  <= '0;
            o_err  <= 1'b0;
        end else begin
            if (rel_go) begin
                chk_id <= rd_ptr;
                chk_h  <= mir_h[rd_ptr];
            end
            if ((o_8row_re && ((i_8row_id != chk_id) || (i_8row_h != chk_h)))
                || (rel_go && i_8row_empty)
                || (i_req_vld && (cnt == 4'd8))
                || ((state == S_FETCH) && !i_fix_h_empty && i_fix_h[14])) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{i_8row_id, i_8row_h, i_fix_h[14]};
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_img_row_pair_sel.sv
// Directed bench for img_row_pair_sel: FIFO models, expected-pair scoreboard, decoupled monitor.
module tb_img_row_pair_sel;

    localparam int W = 33;  // {lat[8], rel[4], oob, id0[3], id1[3], h0[9], frac[5]}

    logic        clk = 1'b0;
    logic        frst_n = 1'b0;
    logic [8:0]  i_req_h;
    logic        i_req_vld;
    logic [14:0] i_fix_h;
    logic        i_fix_h_vld;
    logic        i_fix_h_empty;
    logic        o_fix_h_re;
    logic [2:0]  i_8row_id;
    logic [8:0]  i_8row_h;
    logic        i_8row_empty;
    logic        o_8row_re;
    logic [2:0]  o_pair_id0;
    logic [2:0]  o_pair_id1;
    logic [8:0]  o_pair_h0;
    logic [4:0]  o_pair_frac;
    logic        o_pair_oob;
    logic        o_pair_vld;
    logic        i_pair_ready;
    logic        i_line_done;
    logic        o_err;
    logic [2:0]  o_dbg_state;

    always #5 clk = ~clk;

    img_row_pair_sel #(.IMG_H_MAX(479)) dut (
        .clk          (clk),
        .frst_n       (frst_n),
        .i_req_h      (i_req_h),
        .i_req_vld    (i_req_vld),
        .i_fix_h      (i_fix_h),
        .i_fix_h_vld  (i_fix_h_vld),
        .i_fix_h_empty(i_fix_h_empty),
        .o_fix_h_re   (o_fix_h_re),
        .i_8row_id    (i_8row_id),
        .i_8row_h     (i_8row_h),
        .i_8row_empty (i_8row_empty),
        .o_8row_re    (o_8row_re),
        .o_pair_id0   (o_pair_id0),
        .o_pair_id1   (o_pair_id1),
        .o_pair_h0    (o_pair_h0),
        .o_pair_frac  (o_pair_frac),
        .o_pair_oob   (o_pair_oob),
        .o_pair_vld   (o_pair_vld),
        .i_pair_ready (i_pair_ready),
        .i_line_done  (i_line_done),
        .o_err        (o_err),
        .o_dbg_state  (o_dbg_state)
    );

    logic [W-1:0]  exp_q[$];
    logic [15:0]   fix_q[$];
    logic [11:0]   row_q[$];
    logic [2:0]    wid;
    logic [2:0]    id_xor;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] lat, input logic [3:0] rel,
                                        input logic oob, input logic [2:0] id0,
                                        input logic [2:0] id1, input logic [8:0] h0,
                                        input logic [4:0] frac);
        return {lat, rel, oob, id0, id1, h0, frac};
    endfunction

    // FIFO models: pop on the edge where the DUT's registered read enable is high.
    initial begin
        wid = '0;
        i_fix_h = '0; i_fix_h_vld = 1'b0; i_fix_h_empty = 1'b1;
        i_8row_id = '0; i_8row_h = '0; i_8row_empty = 1'b1;
        forever begin
            @(posedge clk);
            if (!frst_n) begin
                fix_q.delete();
                row_q.delete();
                wid = '0;
            end else begin
                if (o_fix_h_re && fix_q.size() > 0) fix_q.delete(0);
                if (o_8row_re && row_q.size() > 0) row_q.delete(0);
                if (i_req_vld) begin
                    row_q.push_back({wid ^ id_xor, i_req_h});
                    wid = wid + 3'd1;
                end
            end
            #1;
            if (fix_q.size() > 0) begin
                {i_fix_h_vld, i_fix_h} = fix_q[0];
                i_fix_h_empty = 1'b0;
            end else begin
                i_fix_h_empty = 1'b1;
            end
            if (row_q.size() > 0) begin
                {i_8row_id, i_8row_h} = row_q[0];
                i_8row_empty = 1'b0;
            end else begin
                i_8row_empty = 1'b1;
            end
        end
    end

    // Monitor: latency counted from the fix-h pop, releases counted per line.
    initial begin
        int            lat;
        int            rel;
        logic [W-1:0]  e;
        lat = 0;
        rel = 0;
        i_line_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!frst_n) begin
                rel = 0;
                continue;
            end
            if (o_fix_h_re) begin
                lat = 0;
                rel = 0;
            end else begin
                lat++;
            end
            if (o_8row_re) rel++;
            if (o_pair_vld && i_pair_ready) begin
                if (exp_q.size() == 0) begin
                    check("pair_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_oob", 32'(o_pair_oob), 32'(e[20]));
                    check("pair_h0", 32'(o_pair_h0), 32'(e[13:5]));
                    check("pair_frac", 32'(o_pair_frac), 32'(e[4:0]));
                    check("release_count", 32'(rel), 32'(e[24:21]));
                    if (!e[20]) begin
                        check("pair_id0", 32'(o_pair_id0), 32'(e[19:17]));
                        check("pair_id1", 32'(o_pair_id1), 32'(e[16:14]));
                    end
                    if (e[32:25] != 8'hFF) check("pair_latency", 32'(lat), 32'(e[32:25]));
                end
                @(negedge clk);
                @(negedge clk);
                i_line_done = 1'b1;
                @(negedge clk);
                i_line_done = 1'b0;
            end
        end
    end

    task automatic req(input logic [8:0] h);
        i_req_vld = 1'b1;
        i_req_h   = h;
        @(negedge clk);
        i_req_vld = 1'b0;
    endtask

    task automatic push_fix(input logic vld, input logic [14:0] fix, input logic [W-1:0] e);
        fix_q.push_back({vld, fix});
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d pairs outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        i_req_vld = 1'b0;
        i_req_h = '0;
        i_pair_ready = 1'b1;
        id_xor = '0;
        repeat (3) @(negedge clk);
        check("rst_fix_h_re", 32'(o_fix_h_re), 32'd0);
        check("rst_8row_re", 32'(o_8row_re), 32'd0);
        check("rst_pair_vld", 32'(o_pair_vld), 32'd0);
        check("rst_pair_oob", 32'(o_pair_oob), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_id0", 32'(o_pair_id0), 32'd0);
        check("rst_id1", 32'(o_pair_id1), 32'd0);
        check("rst_h0", 32'(o_pair_h0), 32'd0);
        check("rst_frac", 32'(o_pair_frac), 32'd0);
        frst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 8; r++) req(9'(r));
        push_fix(1'b1, 15'h0010, mk(8'd2, 4'd0, 1'b0, 3'd0, 3'd1, 9'd0, 5'd16));
        push_fix(1'b1, 15'h0060, mk(8'd5, 4'd3, 1'b0, 3'd3, 3'd4, 9'd3, 5'd0));
        push_fix(1'b0, 15'h0100, mk(8'd1, 4'd0, 1'b1, 3'd0, 3'd0, 9'd8, 5'd0));
        wait_drain();

        // Row 8 (h1) not yet requested: the pair must wait for its snoop.
        push_fix(1'b1, 15'h00E0, mk(8'hFF, 4'd4, 1'b0, 3'd7, 3'd0, 9'd7, 5'd0));
        repeat (20) @(negedge clk);
        check("wait_rows_hold_vld", 32'(o_pair_vld), 32'd0);
        req(9'd8);
        check("wait_rows_vld_early", 32'(o_pair_vld), 32'd0);
        @(negedge clk);
        check("wait_rows_vld_on_time", 32'(o_pair_vld), 32'd1);
        wait_drain();

        req(9'd100);
        req(9'd479);
        push_fix(1'b1, 15'h3BE5, mk(8'd5, 4'd3, 1'b0, 3'd2, 3'd2, 9'd479, 5'd5));
        push_fix(1'b1, 15'h3BFF, mk(8'd2, 4'd0, 1'b0, 3'd2, 3'd2, 9'd479, 5'd31));
        wait_drain();
        check("err_clean_run", 32'(o_err), 32'd0);

`ifdef IMG_ROW_CHK_EN
        repeat (5) @(negedge clk);
        frst_n = 1'b0;
        repeat (2) @(negedge clk);
        frst_n = 1'b1;
        @(negedge clk);
        id_xor = 3'd5;
        req(9'd0);
        id_xor = 3'd0;
        req(9'd1);
        req(9'd2);
        push_fix(1'b1, 15'h0020, mk(8'd3, 4'd1, 1'b0, 3'd1, 3'd2, 9'd1, 5'd0));
        wait_drain();
        check("err_on_id_mismatch", 32'(o_err), 32'd1);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(o_err), 32'd1);
        frst_n = 1'b0;
        @(negedge clk);
        check("err_cleared_by_reset", 32'(o_err), 32'd0);
        frst_n = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/img_row_pair_sel.md
# img_row_pair_sel

Consumer end of the image read-request / 8-row buffer path, on the bilinear-scaler side. It pops fixed-point source row positions from the fix-h FIFO and resolves the two resident 8-row slots (`floor(h)`, `floor(h)+1`) that the interpolator needs, then hands that row pair over with a ready/valid handshake. It releases superseded rows by popping the 8-row FIFO, which returns space to the request controller. It keeps a local mirror of slot contents, built by snooping the issued read requests, so both rows can be checked without peeking past the FIFO head.

## Interface
- `IMG_H_MAX`, 479, last valid source row; `h1` is clamped to this value.
- `clk` in 1 — system clock.
- `frst_n` in 1 — asynchronous, active-low reset.
- `i_req_h` in 9 — row number of the issued read request (snooped).
- `i_req_vld` in 1 — issued-request strobe; the slot id is implicit (3-bit write pointer, starts at 0, +1 per strobe).
- `i_fix_h` in 15 — source row position, {10-int, 5-frac}; FWFT head of the fix-h FIFO.
- `i_fix_h_vld` in 1 — 1 = row in range; 0 = out-of-range output line.
- `i_fix_h_empty` in 1 — fix-h FIFO empty.
- `o_fix_h_re` out 1 — fix-h FIFO pop.
- `i_8row_id` in 3 — FWFT head of the 8-row FIFO: slot id.
- `i_8row_h` in 9 — FWFT head of the 8-row FIFO: row number.
- `i_8row_empty` in 1 — 8-row FIFO empty.
- `o_8row_re` out 1 — 8-row FIFO pop; releases one slot.
- `o_pair_id0` out 3 — slot holding row `h0`.
- `o_pair_id1` out 3 — slot holding row `h1`.
- `o_pair_h0` out 9 — row number `h0`.
- `o_pair_frac` out 5 — vertical weight.
- `o_pair_oob` out 1 — blank line; ids are don't-care.
- `o_pair_vld` out 1 — pair valid.
- `i_pair_ready` in 1 — interpolator accepts the pair.
- `i_line_done` in 1 — single-cycle pulse: interpolator has finished reading the accepted pair.
- `o_err` out 1 — sticky error (only with `IMG_ROW_CHK_EN`).

## Operation
- **Mirror**
  - 8 entries, each holding `valid` and `h[8:0]`.
  - Pointers `wr_ptr` and `rd_ptr` (3-bit, wrap 7→0) and a 4-bit `cnt` (0..8).
  - `i_req_vld` writes `i_req_h` at `wr_ptr`, then `wr_ptr++` and `cnt++`.
  - Within a frame, rows are strictly increasing from oldest to newest.
- **Derived values**
  - `h0 = i_fix_h[14:5]` (upper bit must be 0).
  - `h1 = (h0 == IMG_H_MAX) ? h0 : h0+1`.
  - `frac = i_fix_h[4:0]`.
- **FSM**
  - IDLE: → FETCH after reset release.
  - FETCH: when `!i_fix_h_empty`, pulse `o_fix_h_re` and capture `h0`, `h1`, `frac`, and `oob = ~i_fix_h_vld`. Go to PRESENT if `oob`, else RELEASE.
  - RELEASE: while `cnt>0` and `h[rd_ptr] < h0`, pulse `o_8row_re` once per cycle, with `rd_ptr++` and `cnt--`. When the condition fails → WAIT_ROWS.
  - WAIT_ROWS: stay until `cnt≥1` and `h[rd_ptr]==h0`, and additionally either `h1==h0` or (`cnt≥2` and `h[rd_ptr+1]==h1`).
    - Then `id0 = rd_ptr`.
    - `id1 = (h1==h0) ? rd_ptr : rd_ptr+1`.
    - → PRESENT.
  - PRESENT: hold `o_pair_vld=1` and all outputs stable until `i_pair_ready` → BUSY.
  - BUSY: wait for `i_line_done` → FETCH.
- **Handshakes**
  - Only one pair is outstanding at a time.
  - Rows are never released while a pair is in PRESENT or BUSY.
- **Simultaneous events**
  - `i_req_vld` together with a release pop in the same cycle: both take effect; `cnt` is unchanged.
  - `i_req_vld` arriving while in WAIT_ROWS is seen by the lookup in the next cycle.
- **Error cases**
  - `i_req_vld` with `cnt==8`: the write is dropped.
  - Release with `i_8row_empty==1`: the pop is suppressed, the mirror still advances, and it is flagged only under the macro.
- **Reset**: asynchronous at any point (including mid-RELEASE or BUSY). Returns to IDLE with pointers, `cnt` and all valid bits cleared.

## Timing
- Reset values:
  - `o_fix_h_re`, `o_8row_re`, `o_pair_vld`, `o_pair_oob`, `o_err` = 0.
  - ids, `h0`, `frac` = 0.
- All outputs are registered.
- FETCH→PRESENT latency:
  - Out-of-range line: 2 cycles.
  - In-range line, rows already resident and nothing to release: 3 cycles.
  - Each released row adds 1 cycle.
- Release throughput: 1 pop per cycle.
- `o_pair_vld` deasserts in the cycle after acceptance.
- The next `o_fix_h_re` comes no earlier than 1 cycle after `i_line_done`.

## Configuration
- `IMG_ROW_CHK_EN` defined: on every `o_8row_re`, compare the FIFO head (`i_8row_id`, `i_8row_h`) with the mirror (`rd_ptr`, `h[rd_ptr]`). Set sticky `o_err` on:
  - a mismatch,
  - a pop while empty,
  - a mirror overflow,
  - `i_fix_h[14]==1`.
- Undefined: no checker logic; `o_err` is tied to 0.

## Test plan
- Snoop rows 0..7, then `fix_h=0x0010` (h0=0, frac=16) → `o_pair_id0=0`, `id1=1`, `frac=16`, no `o_8row_re`.
- Next `fix_h=0x0060` (h0=3) after `i_line_done` → 3 release pulses (rows 0,1,2), then `id0=3`, `id1=4`.
- `fix_h=479<<5`, rows up to 479 resident → `id0==id1`, `o_pair_h0=479`.
- `i_fix_h_vld=0` → `o_pair_oob=1` with no release, presented 2 cycles after FETCH.
- Row h1 not yet requested → stays in WAIT_ROWS with `o_pair_vld=0`; pair presented 1 cycle after the `i_req_vld` for h1.
- With `IMG_ROW_CHK_EN`: 8-row FIFO head id forced to differ from the mirror → `o_err=1`, and it stays set until `frst_n` low.
